// File: rtl/fma_arb_pkg.sv
// Shared types and constants for schedulers that front the BF16 FMA unit.
package fma_arb_pkg;

    localparam int unsigned MAX_N_REQ = 16;
    localparam int unsigned IDX_W_MAX = $clog2(MAX_N_REQ);

    typedef logic [15:0] bf16_t;

    localparam bf16_t BF16_ONE = 16'h3F80;

    // Requester tag carried alongside an op through the FMA pipe.
    typedef struct packed {
        logic                 valid;
        logic [IDX_W_MAX-1:0] idx;
    } fma_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr (modulo N) wins.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IW = $clog2(N);

    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            automatic int unsigned pos = (32'(ptr) + k) % N;
            if (en && !found && req[pos]) begin
                grant[pos] = 1'b1;
                idx        = IW'(pos);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fma_bf16_arbiter.sv
// Round-robin scheduler sharing one pipelined BF16 FMA among N_REQ requesters.
// Optional tag/result consistency check built when FMA_ARB_ERR_CHECK_EN is defined.
module fma_bf16_arbiter
    import fma_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*16-1:0] req_mul0,
    input  logic [N_REQ*16-1:0] req_mul1,
    input  logic [N_REQ*16-1:0] req_add,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [15:0]         rsp_data,
    output logic                fma_in_valid,
    output logic [15:0]         fma_mul0,
    output logic [15:0]         fma_mul1,
    output logic [15:0]         fma_add,
    input  logic [15:0]         fma_out,
    input  logic                fma_out_valid,
    output logic                busy,
    output logic                err
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(LATENCY + 2);

    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    grant_idx;
    logic             hs;
    fma_tag_t         tag_in;
    fma_tag_t         tag_q [LATENCY];
    fma_tag_t         head;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    bf16_t            rsp_data_q;

    // Gating with rst_n keeps req_ready low for the whole reset interval.
    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .en    (en & rst_n),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign req_ready    = grant;
    assign hs           = |grant;
    assign fma_in_valid = hs;

    always_comb begin
        fma_mul0 = '0;
        fma_mul1 = '0;
        fma_add  = '0;
        if (hs) begin
            fma_mul0 = req_mul0[32'(grant_idx)*16 +: 16];
            fma_mul1 = req_mul1[32'(grant_idx)*16 +: 16];
            fma_add  = req_add[32'(grant_idx)*16 +: 16];
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = hs;
        tag_in.idx   = IDX_W_MAX'(grant_idx);
    end

    assign head = tag_q[LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(LATENCY); s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int s = 1; s < int'(LATENCY); s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({hs, head.valid})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        rsp_valid_d = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rsp_valid_d[i] = head.valid && (head.idx == IDX_W_MAX'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            if (head.valid) begin
                rsp_data_q <= fma_out;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (cnt_q != '0) || (|req_valid);

`ifdef FMA_ARB_ERR_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (fma_out_valid != head.valid) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_fma_out_valid;

    assign unused_fma_out_valid = fma_out_valid;
    assign err                  = 1'b0;
`endif

endmodule

// File: tb/tb_fma_bf16_arbiter.sv
// Directed bench for fma_bf16_arbiter; the FMA unit is a 2-stage table of hand-computed results.
module tb_fma_bf16_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned LAT = 2;

`ifdef FMA_ARB_ERR_CHECK_EN
    localparam logic EXP_ERR_SPUR = 1'b1;
`else
    localparam logic EXP_ERR_SPUR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*16-1:0] req_mul0, req_mul1, req_add;
    logic [N-1:0]    rsp_valid;
    logic [15:0]     rsp_data;
    logic            fma_in_valid;
    logic [15:0]     fma_mul0, fma_mul1, fma_add;
    logic [15:0]     fma_out;
    logic            fma_out_valid;
    logic            busy;
    logic            err;

    logic            fm_v [LAT];
    logic [15:0]     fm_d [LAT];
    logic            spur;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected results per requester: r0 2*2+1=5, r1 1*2+0.5=2.5, r2 3*2+1=7, r3 0.5*4+1.5=3.5.
    logic [15:0] exp_res [N];

    always #5 clk = ~clk;

    fma_bf16_arbiter #(
        .N_REQ   (N),
        .LATENCY (LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_mul0      (req_mul0),
        .req_mul1      (req_mul1),
        .req_add       (req_add),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .fma_in_valid  (fma_in_valid),
        .fma_mul0      (fma_mul0),
        .fma_mul1      (fma_mul1),
        .fma_add       (fma_add),
        .fma_out       (fma_out),
        .fma_out_valid (fma_out_valid),
        .busy          (busy),
        .err           (err)
    );

    function automatic logic [15:0] fma_lut(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c);
        logic [47:0] key;
        key = {a, b, c};
        case (key)
            48'h4000_4000_3F80: return 16'h40A0;
            48'h3F80_4000_3F00: return 16'h4020;
            48'h4040_4000_3F80: return 16'h40E0;
            48'h3F00_4080_3FC0: return 16'h4060;
            default:            return 16'hDEAD;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(LAT); s++) begin
                fm_v[s] <= 1'b0;
                fm_d[s] <= '0;
            end
        end else begin
            fm_v[0] <= fma_in_valid;
            fm_d[0] <= fma_lut(fma_mul0, fma_mul1, fma_add);
            for (int s = 1; s < int'(LAT); s++) begin
                fm_v[s] <= fm_v[s-1];
                fm_d[s] <= fm_d[s-1];
            end
        end
    end

    assign fma_out       = fm_d[LAT-1];
    assign fma_out_valid = fm_v[LAT-1] | spur;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        exp_res[0] = 16'h40A0;
        exp_res[1] = 16'h4020;
        exp_res[2] = 16'h40E0;
        exp_res[3] = 16'h4060;
        req_mul0  = {16'h3F00, 16'h4040, 16'h3F80, 16'h4000};
        req_mul1  = {16'h4080, 16'h4000, 16'h4000, 16'h4000};
        req_add   = {16'h3FC0, 16'h3F80, 16'h3F00, 16'h3F80};
        en        = 1'b1;
        spur      = 1'b0;
        rst_n     = 1'b0;
        req_valid = 4'b1111;

        // Reset state with requests pending
        tick();
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_fma_in_valid", 32'(fma_in_valid), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'h0);

        // Single requester: req1 computes 1.0*2.0+0.5
        req_valid = 4'b0010;
        #1;
        check("single_ready", 32'(req_ready), 32'h2);
        check("single_fma_in_valid", 32'(fma_in_valid), 32'h1);
        check("single_mul0", 32'(fma_mul0), 32'h3F80);
        check("single_mul1", 32'(fma_mul1), 32'h4000);
        check("single_add", 32'(fma_add), 32'h3F00);
        tick();
        req_valid = '0;
        #1;
        check("single_t1_rsp", 32'(rsp_valid), 32'h0);
        check("single_t1_busy", 32'(busy), 32'h1);
        check("single_idle_operand", 32'(fma_mul0), 32'h0);
        tick();
        check("single_t2_rsp", 32'(rsp_valid), 32'h0);
        tick();
        check("single_t3_rsp_valid", 32'(rsp_valid), 32'h2);
        check("single_t3_rsp_data", 32'(rsp_data), 32'h4020);
        tick();
        check("single_t4_rsp_valid", 32'(rsp_valid), 32'h0);

        // All four continuously valid from reset
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            if (k == 8) req_valid = '0;
            #1;
            if (k < 8) check($sformatf("all_grant_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 3 && k < 11) begin
                check($sformatf("all_rsp_valid_%0d", k), 32'(rsp_valid),
                      32'(1 << ((k - 3) % 4)));
                check($sformatf("all_rsp_data_%0d", k), 32'(rsp_data),
                      32'(exp_res[(k - 3) % 4]));
            end
            if (k == 11) check("all_rsp_done", 32'(rsp_valid), 32'h0);
            tick();
        end

        // Fairness: after 2, 3 wins over 1
        req_valid = 4'b0100;
        #1;
        check("fair_grant2", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b1010;
        #1;
        check("fair_grant3", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0010;
        #1;
        check("fair_grant1", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        check("fair_rsp2", 32'(rsp_valid), 32'h4);
        tick();
        check("fair_rsp3", 32'(rsp_valid), 32'h8);
        tick();
        check("fair_rsp1", 32'(rsp_valid), 32'h2);
        tick();

        // en low with two ops in flight; rr_ptr is 2 here
        req_valid = 4'b0011;
        #1;
        check("en_grant0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0010;
        #1;
        check("en_grant1", 32'(req_ready), 32'h2);
        tick();
        en        = 1'b0;
        req_valid = 4'b1100;
        #1;
        check("en_off_ready", 32'(req_ready), 32'h0);
        check("en_off_fma_in_valid", 32'(fma_in_valid), 32'h0);
        tick();
        check("en_off_rsp0_valid", 32'(rsp_valid), 32'h1);
        check("en_off_rsp0_data", 32'(rsp_data), 32'h40A0);
        check("en_off_ready_b", 32'(req_ready), 32'h0);
        tick();
        check("en_off_rsp1_valid", 32'(rsp_valid), 32'h2);
        check("en_off_rsp1_data", 32'(rsp_data), 32'h4020);
        check("en_off_busy_reqs", 32'(busy), 32'h1);
        tick();
        req_valid = '0;
        #1;
        check("en_off_busy_fall", 32'(busy), 32'h0);
        en = 1'b1;
        tick();

        // Reset with two ops in flight (ptr is 2: grants 2 then 3)
        req_valid = 4'b1100;
        #1;
        check("rst_mid_grant2", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b1000;
        #1;
        check("rst_mid_grant3", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_mid_no_rsp_%0d", k), 32'(rsp_valid), 32'h0);
            tick();
        end
        req_valid = 4'b1111;
        #1;
        check("rst_mid_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        for (int k = 0; k < 4; k++) tick();

        // Spurious fma_out_valid with the tag pipe empty
        check("spur_err_before", 32'(err), 32'h0);
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("spur_err_set", 32'(err), 32'(EXP_ERR_SPUR));
        check("spur_no_rsp", 32'(rsp_valid), 32'h0);
        tick();
        tick();
        check("spur_err_held", 32'(err), 32'(EXP_ERR_SPUR));
        do_reset();
        #1;
        check("spur_err_cleared", 32'(err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
